am_voice_scheduler: RTL

- Time-multiplexes one shared amplitude-modulator datapath (carrier x (1 + modulator), fixed pipeline latency) among NUM_VOICES voice requesters.
- Round-robin arbitration over per-voice valid/ready inputs.
- Issues one operand pair per cycle into the modulator and tags each issue with its voice ID.
- Re-associates each tag with the returning modulator result and presents it on a single tagged output stream.
- Sits between the voice generators and the mixer.

---
 rtl/am_voice_scheduler.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/am_voice_scheduler.sv
// am_voice_scheduler: shares one fixed-latency amplitude modulator among
// NUM_VOICES requesters. Requests are granted round-robin, issued one per
// cycle with a voice tag, and each returning result is re-tagged and
// presented on a single output stream in issue order.
module am_voice_scheduler #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_VOICES  = 4,
  parameter int MOD_LATENCY = 3,
  localparam int VID_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             enable_i,
  input  logic [NUM_VOICES-1:0]            req_valid_i,
  output logic [NUM_VOICES-1:0]            req_ready_o,
  input  logic [NUM_VOICES*DATA_WIDTH-1:0] req_carrier_i,
  input  logic [NUM_VOICES*DATA_WIDTH-1:0] req_mod_i,
  output logic                             mod_valid_o,
  output logic [DATA_WIDTH-1:0]            mod_carrier_o,
  output logic [DATA_WIDTH-1:0]            mod_mod_o,
  input  logic [DATA_WIDTH-1:0]            mod_result_i,
  output logic                             out_valid_o,
  output logic [VID_W-1:0]                 out_voice_o,
  output logic [DATA_WIDTH-1:0]            out_data_o,
  output logic                             busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [VID_W-1:0]        rr_ptr_reg, rr_ptr_next;

  logic                    grant_found;
  logic [VID_W-1:0]        grant_idx;
  logic [VID_W:0]          cand;
  logic                    arb_en;
  logic                    xfer;
  logic                    in_flight;

  logic                    mod_valid_reg;
  logic [DATA_WIDTH-1:0]   mod_carrier_reg;
  logic [DATA_WIDTH-1:0]   mod_mod_reg;
  logic [VID_W-1:0]        issue_vid_reg;

  logic                    tag_valid_reg [MOD_LATENCY];
  logic [VID_W-1:0]        tag_vid_reg   [MOD_LATENCY];
  logic                    tag_valid_next [MOD_LATENCY];
  logic [VID_W-1:0]        tag_vid_next   [MOD_LATENCY];

  logic                    out_valid_reg;
  logic [VID_W-1:0]        out_voice_reg;
  logic [DATA_WIDTH-1:0]   out_data_reg;

  // Round-robin search: first valid voice starting at rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      cand = {1'b0, rr_ptr_reg} + (VID_W+1)'(i);
      if (cand >= (VID_W+1)'(NUM_VOICES)) begin
        cand = cand - (VID_W+1)'(NUM_VOICES);
      end
      if (!grant_found && req_valid_i[cand[VID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[VID_W-1:0];
      end
    end
  end

  // Grants only while running; dropping enable_i withdraws ready at once.
  assign arb_en = (state_reg == ST_RUN) && enable_i;
  assign xfer   = arb_en && grant_found;

  // One-hot ready for the granted voice; pointer advances past the winner.
  always_comb begin
    req_ready_o = '0;
    rr_ptr_next = rr_ptr_reg;
    if (xfer) begin
      req_ready_o[grant_idx] = 1'b1;
      rr_ptr_next = (grant_idx == VID_W'(NUM_VOICES-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Anything still owed to the output: issue stage or any tag stage.
  always_comb begin
    in_flight = mod_valid_reg;
    for (int i = 0; i < MOD_LATENCY; i++) begin
      in_flight = in_flight | tag_valid_reg[i];
    end
  end

  // Next-state logic for the run/drain control FSM.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (enable_i) state_next = ST_RUN;
      ST_RUN:   if (!enable_i) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (enable_i)        state_next = ST_RUN;
        else if (!in_flight) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  assign busy_o = (state_reg != ST_IDLE);

  // State and round-robin pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= ST_IDLE;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Issue stage: capture the granted voice's operands and ID; hold otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mod_valid_reg   <= 1'b0;
      mod_carrier_reg <= '0;
      mod_mod_reg     <= '0;
      issue_vid_reg   <= '0;
    end else begin
      mod_valid_reg <= xfer;
      if (xfer) begin
        mod_carrier_reg <= req_carrier_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        mod_mod_reg     <= req_mod_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        issue_vid_reg   <= grant_idx;
      end
    end
  end

  assign mod_valid_o   = mod_valid_reg;
  assign mod_carrier_o = mod_carrier_reg;
  assign mod_mod_o     = mod_mod_reg;

  // Tag pipeline inputs: stage 0 takes the issue stage, later stages shift.
  genvar gi;
  generate
    for (gi = 0; gi < MOD_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_valid_next[gi] = mod_valid_reg;
        assign tag_vid_next[gi]   = issue_vid_reg;
      end else begin : g_body
        assign tag_valid_next[gi] = tag_valid_reg[gi-1];
        assign tag_vid_next[gi]   = tag_vid_reg[gi-1];
      end
    end
  endgenerate

  // Tag shift register, last stage lines up with mod_result_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MOD_LATENCY; i++) begin
        tag_valid_reg[i] <= 1'b0;
        tag_vid_reg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < MOD_LATENCY; i++) begin
        tag_valid_reg[i] <= tag_valid_next[i];
        tag_vid_reg[i]   <= tag_vid_next[i];
      end
    end
  end

  // Output register: re-associate the emerging tag with the result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_reg <= 1'b0;
      out_voice_reg <= '0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= tag_valid_reg[MOD_LATENCY-1];
      if (tag_valid_reg[MOD_LATENCY-1]) begin
        out_voice_reg <= tag_vid_reg[MOD_LATENCY-1];
        out_data_reg  <= mod_result_i;
      end
    end
  end

  assign out_valid_o = out_valid_reg;
  assign out_voice_o = out_voice_reg;
  assign out_data_o  = out_data_reg;

endmodule
